affine_shares_serial: RTL and testbench
=======================================

AFFINE_SHARES_SERIAL -- requirements
Module: affine_shares_serial

Interface
REQ-001 SHALL have parameter N_SHARES, default 3, meaning the number of Boolean shares (at least 2).
REQ-002 SHALL have parameter N_NIBBLES, default 16, meaning the number of 4-bit nibbles per share.
REQ-003 SHALL have parameter LANES, default 4, meaning nibbles processed per cycle per share; LANES SHALL divide N_NIBBLES; K = N_NIBBLES/LANES.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: an input state is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a state.
REQ-008 SHALL have port in_inv, input, 1 bit: 0 selects the forward affine map A, 1 selects the inverse A^-1.
REQ-009 SHALL have port in_data, input, N_SHARES*4*N_NIBBLES bits: share s occupies slice [s*4*N_NIBBLES +: 4*N_NIBBLES]; nibble j of a share occupies [4j +: 4].
REQ-010 SHALL have port out_valid, output, 1 bit: the result is available.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port out_data, output, N_SHARES*4*N_NIBBLES bits: the shared result, with the same layout as in_data.

Function
REQ-013 The linear map L SHALL be y3=x0, y2=x3^x0, y1=x2^x3, y0=x1^x2, with constant C=4'hC.
REQ-014 Forward mode: share 0 SHALL compute L(x)^C; every other share SHALL compute L(x).
REQ-015 Inverse mode: share 0 SHALL compute L^-1(x^C); every other share SHALL compute L^-1(x).
REQ-016 L^-1 SHALL be x0=y3, x3=y2^y3, x2=y1^y2^y3, x1=y0^y1^y2^y3.
REQ-017 The output bits of each share SHALL depend only on the same share's input bits; no cross-share logic or shared registers are permitted (non-completeness).
REQ-018 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-019 IDLE: in_ready=1; on in_valid=1 the block SHALL load in_data and latch in_inv, set cnt=0, and go to RUN.
REQ-020 RUN: in_ready=0; each cycle the block SHALL transform nibbles cnt*LANES..cnt*LANES+LANES-1 of every share in place; when cnt=K-1 it SHALL go to DONE, otherwise cnt increments.
REQ-021 out_valid SHALL rise exactly K+1 rising edges after the accepting edge (default: 5).
REQ-022 DONE: out_valid=1, in_ready=0, and out_data SHALL be held stable; on out_ready=1 the block SHALL go to IDLE with out_valid=0 the next cycle.
REQ-023 Changes of in_valid, in_inv or in_data outside IDLE SHALL have no effect.
REQ-024 out_ready outside DONE SHALL be ignored; no input is accepted in the cycle that DONE exits (in_ready is 0 there).
REQ-025 cnt SHALL be ceil(log2(K)) bits wide (minimum 1) and SHALL never exceed K-1.

Reset
REQ-026 rst_n=0 SHALL immediately set: state=IDLE, cnt=0, the data register to all zero, the mode register to 0, out_valid=0, in_ready=1 after release, and out_data all zero.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation with no partial result retained.

Structure
REQ-028 Package prince_ti_pkg SHALL hold the state enum, the L and L^-1 bit equations as functions, and the constant C.
REQ-029 One combinational sub-module, affine_nibble, SHALL be used, with ports x[3:0], inv, const_en and y[3:0]; const_en=1 only for share 0.
REQ-030 The design SHALL use N_SHARES*LANES instances of affine_nibble, generated per share.

Verification
REQ-031 Forward, all shares 0: out share 0 SHALL be all 4'hC nibbles, and shares 1..N-1 SHALL be all 0.
REQ-032 Forward, share 0 all 4'h1 and others 0: all out shares SHALL be 0; inverse mode with share 0 all 4'h0 SHALL give share 0 all 4'h1.
REQ-033 Random 3-share states, forward then inverse: the unmasked XOR SHALL round-trip to the original; each share changed alone SHALL affect only that output share.
REQ-034 Handshake: in_valid held high SHALL be accepted once; out_valid SHALL rise 5 edges later; holding out_ready=0 for 10 cycles SHALL keep out_data stable; then in_ready=1 the cycle after out_ready.
REQ-035 Asserting rst_n=0 at RUN cnt=2 SHALL give out_valid=0, out_data=0 and in_ready=1 after release, with no stale output.
REQ-036 The parameter sweep SHALL cover N_SHARES in {2,3,4} and LANES in {1,16} (K=16 and K=1), matching a golden model.

Source files
------------

// File: rtl/prince_ti_pkg.sv
// Shared definitions for the threshold-implemented affine layer: FSM states,
// the 4-bit linear map L and its inverse, and the affine constant.
package prince_ti_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] AFF_C = 4'hC;

    // Result is packed {y3, y2, y1, y0}.
    function automatic logic [3:0] lin_fwd(input logic [3:0] x);
        return {x[0], x[3] ^ x[0], x[2] ^ x[3], x[1] ^ x[2]};
    endfunction

    // Result is packed {x3, x2, x1, x0}.
    function automatic logic [3:0] lin_inv(input logic [3:0] y);
        return {y[2] ^ y[3],
                y[1] ^ y[2] ^ y[3],
                y[0] ^ y[1] ^ y[2] ^ y[3],
                y[3]};
    endfunction

endpackage

// File: rtl/affine_nibble.sv
// One nibble of one share through the affine map; only share 0 carries the
// constant so the XOR of all shares sees it exactly once.
module affine_nibble
    import prince_ti_pkg::*;
(
    input  logic [3:0] x,
    input  logic       inv,
    input  logic       const_en,
    output logic [3:0] y
);

    logic [3:0] c;

    assign c = const_en ? AFF_C : 4'h0;
    assign y = inv ? lin_inv(x ^ c) : (lin_fwd(x) ^ c);

endmodule

// File: rtl/affine_shares_serial.sv
// Serial shared affine layer: LANES nibbles of every share are rewritten in
// place per cycle; each share only ever sees its own bits.
//
// Handshake: a state is taken on a rising edge with in_valid=1 and in_ready=1;
// the result is handed over on a rising edge with out_valid=1 and out_ready=1.
// out_data is stable for as long as out_valid is held.
module affine_shares_serial
    import prince_ti_pkg::*;
#(
    parameter int N_SHARES  = 3,
    parameter int N_NIBBLES = 16,
    parameter int LANES     = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_inv,
    input  logic [N_SHARES*4*N_NIBBLES-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N_SHARES*4*N_NIBBLES-1:0] out_data,
    output logic [1:0]                      dbg_state_o
);

    localparam int SW = 4 * N_NIBBLES;
    localparam int W  = N_SHARES * SW;
    localparam int K  = N_NIBBLES / LANES;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    data_q;
    logic [W-1:0]    data_d;
    logic            inv_q;
    logic            out_valid_q;
    logic            in_ready_q;
    logic [W-1:0]    out_data_q;

    logic [3:0] lane_x [N_SHARES][LANES];
    logic [3:0] lane_y [N_SHARES][LANES];

    // Window of nibbles selected by cnt, per share and lane.
    always_comb begin
        for (int s = 0; s < N_SHARES; s++) begin
            for (int l = 0; l < LANES; l++) begin
                lane_x[s][l] = data_q[s*SW + (int'(cnt_q)*LANES + l)*4 +: 4];
            end
        end
    end

    for (genvar s = 0; s < N_SHARES; s++) begin : g_share
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            affine_nibble u_nib (
                .x        (lane_x[s][l]),
                .inv      (inv_q),
                .const_en (s == 0),
                .y        (lane_y[s][l])
            );
        end
    end

    always_comb begin
        data_d = data_q;
        for (int s = 0; s < N_SHARES; s++) begin
            for (int l = 0; l < LANES; l++) begin
                data_d[s*SW + (int'(cnt_q)*LANES + l)*4 +: 4] = lane_y[s][l];
            end
        end
    end

    // DONE spends its first cycle publishing the result into out_data_q, so
    // out_valid rises K+1 edges after acceptance and out_ready is only
    // honoured once the result is actually visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        inv_q      <= in_inv;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    data_q <= data_d;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= data_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_affine_shares_serial.sv
// Bench for affine_shares_serial: default instance plus two sweep instances
// (2 shares / K=16 and 4 shares / K=1) checked against a nibble-level model.
module tb_affine_shares_serial;
    import prince_ti_pkg::*;

    localparam int W  = 192;
    localparam int K  = 4;
    localparam int W2 = 128;
    localparam int K2 = 16;
    localparam int W4 = 256;
    localparam int K4 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          in_valid, in_ready, in_inv, out_valid, out_ready;
    logic [W-1:0]  in_data, out_data;
    logic [1:0]    dbg_state;

    logic          s2_in_valid, s2_in_ready, s2_in_inv, s2_out_valid, s2_out_ready;
    logic [W2-1:0] s2_in_data, s2_out_data;
    logic [1:0]    s2_dbg_state;

    logic          s4_in_valid, s4_in_ready, s4_in_inv, s4_out_valid, s4_out_ready;
    logic [W4-1:0] s4_in_data, s4_out_data;
    logic [1:0]    s4_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0]  exp_q[$];
    logic [255:0]  sw_q[$];

    typedef struct {
        logic         inv;
        logic [W-1:0] data;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vt [8];

    always #5 clk = ~clk;

    affine_shares_serial #(.N_SHARES(3), .N_NIBBLES(16), .LANES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .dbg_state_o(dbg_state)
    );

    affine_shares_serial #(.N_SHARES(2), .N_NIBBLES(16), .LANES(1)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(s2_in_valid), .in_ready(s2_in_ready),
        .in_inv(s2_in_inv), .in_data(s2_in_data), .out_valid(s2_out_valid),
        .out_ready(s2_out_ready), .out_data(s2_out_data), .dbg_state_o(s2_dbg_state)
    );

    affine_shares_serial #(.N_SHARES(4), .N_NIBBLES(16), .LANES(16)) u_dut_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(s4_in_valid), .in_ready(s4_in_ready),
        .in_inv(s4_in_inv), .in_data(s4_in_data), .out_valid(s4_out_valid),
        .out_ready(s4_out_ready), .out_data(s4_out_data), .dbg_state_o(s4_dbg_state)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [3:0] l_fwd_m(input logic [3:0] x);
        return {x[0], x[3] ^ x[0], x[2] ^ x[3], x[1] ^ x[2]};
    endfunction

    // Inverse found by exhaustive search over the forward map.
    function automatic logic [3:0] nib_model(input logic [3:0] x, input logic inv, input logic s0);
        logic [3:0] c;
        logic [3:0] r;
        c = s0 ? 4'hC : 4'h0;
        r = 4'h0;
        if (!inv) begin
            r = l_fwd_m(x) ^ c;
        end else begin
            for (int v = 0; v < 16; v++) begin
                if (l_fwd_m(4'(v)) == (x ^ c)) r = 4'(v);
            end
        end
        return r;
    endfunction

    function automatic logic [255:0] gold(input int ns, input logic inv, input logic [255:0] d);
        logic [255:0] r;
        r = '0;
        for (int s = 0; s < ns; s++) begin
            for (int j = 0; j < 16; j++) begin
                r[s*64 + j*4 +: 4] = nib_model(d[s*64 + j*4 +: 4], inv, s == 0);
            end
        end
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_txn(input logic inv, input logic [W-1:0] data,
                          input logic [W-1:0] exp, output logic [W-1:0] got);
        int n;
        logic [W-1:0] e;
        @(negedge clk);
        in_valid = 1'b1;
        in_inv   = inv;
        in_data  = data;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 256'(in_ready), 256'(1'b1));
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_inv   = ~inv;
        in_data  = ~data;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 256'(n), 256'(K + 1));
        e = exp_q.pop_front();
        chk("out_data", 256'(out_data), 256'(e));
        got = out_data;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", 256'(out_valid), 256'(1'b0));
        chk("release_ready", 256'(in_ready), 256'(1'b1));
    endtask

    task automatic sweep2(input logic inv, input logic [W2-1:0] d);
        int n;
        logic [255:0] g;
        sw_q.push_back(gold(2, inv, 256'(d)));
        @(negedge clk);
        chk("s2_in_ready", 256'(s2_in_ready), 256'(1'b1));
        s2_in_valid = 1'b1;
        s2_in_inv   = inv;
        s2_in_data  = d;
        @(posedge clk);
        #1;
        s2_in_valid = 1'b0;
        n = 0;
        while (!s2_out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("s2_latency", 256'(n), 256'(K2 + 1));
        g = sw_q.pop_front();
        chk("s2_data", 256'(s2_out_data), g);
        s2_out_ready = 1'b1;
        @(posedge clk);
        #1;
        s2_out_ready = 1'b0;
        chk("s2_release", 256'(s2_out_valid), 256'(1'b0));
    endtask

    task automatic sweep4(input logic inv, input logic [W4-1:0] d);
        int n;
        logic [255:0] g;
        sw_q.push_back(gold(4, inv, d));
        @(negedge clk);
        chk("s4_in_ready", 256'(s4_in_ready), 256'(1'b1));
        s4_in_valid = 1'b1;
        s4_in_inv   = inv;
        s4_in_data  = d;
        @(posedge clk);
        #1;
        s4_in_valid = 1'b0;
        n = 0;
        while (!s4_out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("s4_latency", 256'(n), 256'(K4 + 1));
        g = sw_q.pop_front();
        chk("s4_data", s4_out_data, g);
        s4_out_ready = 1'b1;
        @(posedge clk);
        #1;
        s4_out_ready = 1'b0;
        chk("s4_release", 256'(s4_out_valid), 256'(1'b0));
    endtask

    initial begin
        logic [255:0] t;
        logic [W-1:0] got, got2, d, e, snap;
        logic [63:0]  xm, ym, xe;
        int n, extra;

        in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0;
        s2_in_valid = 1'b0; s2_in_inv = 1'b0; s2_in_data = '0; s2_out_ready = 1'b0;
        s4_in_valid = 1'b0; s4_in_inv = 1'b0; s4_in_data = '0; s4_out_ready = 1'b0;

        // Reset block
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_state", 256'(dbg_state), 256'(IDLE));
        chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
        chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
        chk("rst_out_data", 256'(out_data), 256'(0));
        chk("rst_s2_state", 256'(s2_dbg_state), 256'(IDLE));
        chk("rst_s4_state", 256'(s4_dbg_state), 256'(IDLE));

        // Vector table
        vt[0].inv = 1'b0; vt[0].data = '0; vt[0].exp = {128'h0, 64'hCCCC_CCCC_CCCC_CCCC};
        vt[1].inv = 1'b0; vt[1].data = {128'h0, 64'h1111_1111_1111_1111}; vt[1].exp = '0;
        vt[2].inv = 1'b1; vt[2].data = '0; vt[2].exp = {128'h0, 64'h1111_1111_1111_1111};
        vt[3].inv = 1'b1; vt[3].data = {128'h0, 64'hCCCC_CCCC_CCCC_CCCC};
        t = rnd256();
        vt[4].inv = 1'b0; vt[4].data = t[W-1:0];
        t = rnd256();
        vt[5].inv = 1'b0; vt[5].data = vt[4].data; vt[5].data[127:64]  = t[63:0];
        vt[6].inv = 1'b0; vt[6].data = vt[4].data; vt[6].data[191:128] = t[127:64];
        t = rnd256();
        vt[7].inv = 1'b1; vt[7].data = t[W-1:0];
        for (int i = 3; i < 8; i++) begin
            t = gold(3, vt[i].inv, 256'(vt[i].data));
            vt[i].exp = t[W-1:0];
        end
        for (int i = 0; i < 8; i++) begin
            do_txn(vt[i].inv, vt[i].data, vt[i].exp, got);
        end

        // Round trip of the unmasked value
        for (int r = 0; r < 3; r++) begin
            t = rnd256();
            d = t[W-1:0];
            t = gold(3, 1'b0, 256'(d));
            do_txn(1'b0, d, t[W-1:0], got);
            xm = d[63:0] ^ d[127:64] ^ d[191:128];
            ym = got[63:0] ^ got[127:64] ^ got[191:128];
            for (int j = 0; j < 16; j++) xe[j*4 +: 4] = l_fwd_m(xm[j*4 +: 4]) ^ 4'hC;
            chk("unmasked_fwd", 256'(ym), 256'(xe));
            do_txn(1'b1, got, d, got2);
            chk("round_trip", 256'(got2), 256'(d));
        end

        // in_valid held high, inputs churned, out_ready pulsed during RUN
        t = rnd256();
        d = t[W-1:0];
        t = gold(3, 1'b0, 256'(d));
        exp_q.push_back(t[W-1:0]);
        @(negedge clk);
        in_valid = 1'b1; in_inv = 1'b0; in_data = d;
        @(posedge clk);
        #1;
        n = 0;
        extra = 0;
        while (!out_valid && n < 50) begin
            t = rnd256();
            in_data   = t[W-1:0];
            in_inv    = ~in_inv;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            n++;
            if (in_ready) extra++;
        end
        out_ready = 1'b0;
        chk("held_latency", 256'(n), 256'(K + 1));
        chk("held_single_accept", 256'(extra), 256'(0));
        e = exp_q.pop_front();
        chk("held_data", 256'(out_data), 256'(e));
        snap = e;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("stall_data", 256'(out_data), 256'(snap));
        end
        chk("stall_valid", 256'(out_valid), 256'(1'b1));
        chk("stall_in_ready", 256'(in_ready), 256'(1'b0));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("stall_exit_ready", 256'(in_ready), 256'(1'b1));
        chk("stall_exit_valid", 256'(out_valid), 256'(1'b0));

        // Reset while RUN at cnt=2
        @(negedge clk);
        t = rnd256();
        in_valid = 1'b1; in_inv = 1'b0; in_data = t[W-1:0];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("abort_state_run", 256'(dbg_state), 256'(RUN));
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 256'(out_valid), 256'(1'b0));
        chk("abort_out_data", 256'(out_data), 256'(0));
        chk("abort_state", 256'(dbg_state), 256'(IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready", 256'(in_ready), 256'(1'b1));
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid || out_data != '0) n++;
        end
        chk("abort_no_stale", 256'(n), 256'(0));
        t = rnd256();
        e = t[W-1:0];
        t = gold(3, 1'b1, 256'(e));
        do_txn(1'b1, e, t[W-1:0], got);

        // Parameter sweep
        for (int r = 0; r < 3; r++) begin
            t = rnd256();
            sweep2(r[0], t[W2-1:0]);
            t = rnd256();
            sweep4(r[0], t);
        end
        sweep2(1'b0, '0);
        sweep4(1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
